audio_sample_out: RTL and testbench
===================================

AUDIO_SAMPLE_OUT -- requirements
Module: audio_sample_out

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO depth in samples (power of 2, >=2).
REQ-002 SHALL have parameter SAMPLE_DIV, default 1134, clk cycles per output frame (>=18).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port sample_valid  input  1  processor write-back strobe carrying a sample.
REQ-006 SHALL have port sample_data  input  32  processor write-back value (ResultW), signed.
REQ-007 SHALL have port sample_ready  output  1  FIFO can accept a sample (not full).
REQ-008 SHALL have port clr_flags  input  1  synchronous clear of sticky flags.
REQ-009 SHALL have port level  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-010 SHALL have port overflow  output  1  sticky: a sample was dropped.
REQ-011 SHALL have port underrun  output  1  sticky: a frame started with FIFO empty.
REQ-012 SHALL have port dac_sync  output  1  high during the first bit of each frame.
REQ-013 SHALL have port dac_sdata  output  1  serial sample, MSB first.

Function
REQ-014 SHALL convert sample_data to 16-bit sample by taking bits [15:0] (truncation) unless REQ-030 applies.
REQ-015 SHALL push when sample_valid && sample_ready; sample_ready = (level != DEPTH).
REQ-016 SHALL drop a sample and set overflow when sample_valid && level == DEPTH and no pop occurs that cycle.
REQ-017 SHALL accept the push when full if a pop occurs the same cycle; level unchanged.
REQ-018 SHALL run a frame counter 0..SAMPLE_DIV-1, wrapping; tick asserted when count == SAMPLE_DIV-1.
REQ-019 SHALL implement FSM states IDLE and SHIFT.
REQ-020 SHALL, on tick in IDLE: pop FIFO head into 16-bit shift register, bit counter = 15, go SHIFT.
REQ-021 SHALL, on tick with FIFO empty, load 16'h0000, set underrun, still enter SHIFT; a same-cycle push is stored, not popped.
REQ-022 SHALL in SHIFT drive dac_sdata = shift[15], shift left by 1 and decrement bit counter each cycle; after counter 0 return to IDLE (exactly 16 SHIFT cycles).
REQ-023 SHALL drive dac_sync = 1 only in the SHIFT cycle with bit counter 15; dac_sdata = 0 and dac_sync = 0 in IDLE.
REQ-024 SHALL ignore tick while in SHIFT (cannot occur for SAMPLE_DIV >= 18).
REQ-025 SHALL clear overflow/underrun when clr_flags = 1; a same-cycle set event wins over clear.
REQ-026 SHALL wrap FIFO read/write pointers modulo DEPTH.

Reset
REQ-027 SHALL on rst = 0 asynchronously: FSM IDLE, frame counter 0, pointers 0, level 0, shift register 0, overflow 0, underrun 0, dac_sync 0, dac_sdata 0, sample_ready 1.
REQ-028 SHALL abort any frame in progress on reset; FIFO contents are discarded.
REQ-029 SHALL produce first tick SAMPLE_DIV cycles after reset release.

Configuration
REQ-030 SHALL, with macro AUDIO_SAMPLE_SAT_EN defined, saturate sample_data to [-32768, 32767] (e.g. 32'h0001_0000 -> 16'h7FFF, 32'hFFFE_0000 -> 16'h8000); without it, truncate per REQ-014.

Structure
REQ-031 SHALL place in shared package audio_pkg: sample_t (16-bit signed), FSM state enum, SAMPLE_W = 16, default DEPTH and SAMPLE_DIV constants.
REQ-032 SHALL implement storage as sub-module sample_fifo (push, pop, data in/out, level, full, empty); FSM, divider, saturation and serializer stay in audio_sample_out.

Verification
REQ-033 Reset then push 16'hA5C3, wait tick -> dac_sync 1 for one cycle, dac_sdata bits 1010010111000011 over 16 cycles, then IDLE.
REQ-034 Push 17 samples with DEPTH=16 and no tick -> level 16, sample_ready 0, 17th dropped, overflow 1; clr_flags -> overflow 0.
REQ-035 Tick with empty FIFO -> 16 zero bits, dac_sync pulse, underrun 1; same-cycle push -> level 1 afterwards.
REQ-036 Full FIFO, push coincident with tick -> level stays 16, overflow stays 0, pushed value emerges 16 frames later.
REQ-037 Assert rst = 0 mid-frame (bit 8) -> dac_sdata/dac_sync 0 immediately, level 0, next tick SAMPLE_DIV cycles after release.
REQ-038 With AUDIO_SAMPLE_SAT_EN: push 32'h0001_0000 and 32'hFFFE_0000 -> serial 16'h7FFF then 16'h8000; without it -> 16'h0000 then 16'h0000.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared types and defaults for the audio sample serializer.
// The saturate helper is used only when AUDIO_SAMPLE_SAT_EN is defined.
package audio_pkg;

    localparam int SAMPLE_W       = 16;
    localparam int DEF_DEPTH      = 16;
    localparam int DEF_SAMPLE_DIV = 1134;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Clamp a signed 32-bit value into the 16-bit sample range.
    function automatic sample_t sat16(input logic signed [31:0] x);
        if (x > 32'sd32767) begin
            return 16'h7FFF;
        end else if (x < -32'sd32768) begin
            return 16'h8000;
        end else begin
            return x[15:0];
        end
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Sample storage for audio_sample_out: power-of-2 circular buffer with
// occupancy count. A push while full is legal only alongside a pop.
module sample_fifo
    import audio_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  sample_t                  wdata,
    output sample_t                  rdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    sample_t          mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [LW-1:0]    level_q, level_d;

    always_comb begin
        wr_d    = push ? wr_q + AW'(1) : wr_q;
        rd_d    = pop  ? rd_q + AW'(1) : rd_q;
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
        end
    end

    // Contents need no reset: the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= wdata;
    end

    assign rdata = mem_q[rd_q];
    assign level = level_q;
    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);

endmodule

// File: rtl/audio_sample_out.sv
// Buffers processor write-back samples and serializes one per frame, MSB first.
// Define AUDIO_SAMPLE_SAT_EN to saturate (instead of truncate) to 16 bits.
module audio_sample_out
    import audio_pkg::*;
#(
    parameter int DEPTH      = DEF_DEPTH,
    parameter int SAMPLE_DIV = DEF_SAMPLE_DIV
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sample_valid,
    input  logic [31:0]              sample_data,
    output logic                     sample_ready,
    input  logic                     clr_flags,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     underrun,
    output logic                     dac_sync,
    output logic                     dac_sdata
);

    localparam int CW = $clog2(SAMPLE_DIV);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick;
    state_t        state_q, state_d;
    sample_t       shift_q, shift_d;
    logic [3:0]    bit_q, bit_d;
    logic          overflow_q, overflow_d;
    logic          underrun_q, underrun_d;

    logic          push, pop, full, empty;
    logic          ovf_set, und_set;
    sample_t       sample_in, fifo_rdata;

`ifdef AUDIO_SAMPLE_SAT_EN
    assign sample_in = sat16($signed(sample_data));
`else
    logic sample_hi_unused;
    assign sample_in        = sample_data[15:0];
    assign sample_hi_unused = ^sample_data[31:16];
`endif

    sample_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (sample_in),
        .rdata (fifo_rdata),
        .level (level),
        .full  (full),
        .empty (empty)
    );

    assign tick = (cnt_q == CW'(SAMPLE_DIV - 1));

    always_comb begin
        cnt_d   = tick ? '0 : cnt_q + CW'(1);
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        pop     = 1'b0;
        und_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d = SHIFT;
                    bit_d   = 4'd15;
                    if (empty) begin
                        shift_d = '0;
                        und_set = 1'b1;
                    end else begin
                        shift_d = fifo_rdata;
                        pop     = 1'b1;
                    end
                end
            end
            SHIFT: begin
                shift_d = shift_q << 1;
                bit_d   = bit_q - 4'd1;
                if (bit_q == 4'd0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push       = sample_valid && (!full || pop);
        ovf_set    = sample_valid && full && !pop;
        overflow_d = ovf_set || (overflow_q && !clr_flags);
        underrun_d = und_set || (underrun_q && !clr_flags);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q      <= '0;
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_q      <= '0;
            overflow_q <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_q      <= bit_d;
            overflow_q <= overflow_d;
            underrun_q <= underrun_d;
        end
    end

    assign sample_ready = !full;
    assign overflow     = overflow_q;
    assign underrun     = underrun_q;
    assign dac_sdata    = (state_q == SHIFT) && shift_q[15];
    assign dac_sync     = (state_q == SHIFT) && (bit_q == 4'd15);

endmodule

// File: tb/tb_audio_sample_out.sv
// Directed bench for audio_sample_out: framing, overflow, underrun, reset, width conversion.
module tb_audio_sample_out;

    localparam int DEPTH = 16;
    localparam int DIV   = 40;

    logic        clk;
    logic        rst;
    logic        sample_valid;
    logic [31:0] sample_data;
    logic        sample_ready;
    logic        clr_flags;
    logic [4:0]  level;
    logic        overflow;
    logic        underrun;
    logic        dac_sync;
    logic        dac_sdata;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    int cyc    = 0;

    audio_sample_out #(.DEPTH(DEPTH), .SAMPLE_DIV(DIV)) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .sample_ready (sample_ready),
        .clr_flags    (clr_flags),
        .level        (level),
        .overflow     (overflow),
        .underrun     (underrun),
        .dac_sync     (dac_sync),
        .dac_sdata    (dac_sdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic step_to(input int n);
        while (cyc < n) step();
    endtask

    // Called in the sync cycle; leaves the bench in the bit-0 cycle.
    task automatic read_frame(output logic [15:0] w);
        w = '0;
        for (int i = 0; i < 16; i++) begin
            w = {w[14:0], dac_sdata};
            if (i == 1) chk("sync_one_cycle", dac_sync, 1'b0);
            if (i < 15) step();
        end
    endtask

    logic [15:0] w;
    logic [15:0] exp_w;

    initial begin
        rst          = 1'b0;
        sample_valid = 1'b0;
        sample_data  = '0;
        clr_flags    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_level",    level,        5'd0);
        chk("rst_ready",    sample_ready, 1'b1);
        chk("rst_overflow", overflow,     1'b0);
        chk("rst_underrun", underrun,     1'b0);
        chk("rst_sync",     dac_sync,     1'b0);
        chk("rst_sdata",    dac_sdata,    1'b0);

        // Single sample, first frame timing after release
        rst = 1'b1;
        cyc = 0;
        sample_valid = 1'b1;
        sample_data  = 32'h0000_A5C3;
        step();
        sample_valid = 1'b0;
        chk("push1_level", level, 5'd1);
        step_to(DIV - 1);
        chk("pre_tick_sync", dac_sync, 1'b0);
        step();
        chk("first_tick_sync", dac_sync, 1'b1);
        read_frame(w);
        chk("frame_a5c3", w, 16'hA5C3);
        step();
        chk("idle_sdata",    dac_sdata, 1'b0);
        chk("idle_sync",     dac_sync,  1'b0);
        chk("idle_level",    level,     5'd0);
        chk("idle_underrun", underrun,  1'b0);

        // Fill past capacity between ticks
        for (int i = 0; i < 17; i++) begin
            sample_valid = 1'b1;
            sample_data  = 32'h100 + i;
            step();
        end
        sample_valid = 1'b0;
        chk("full_level",    level,        5'd16);
        chk("full_ready",    sample_ready, 1'b0);
        chk("full_overflow", overflow,     1'b1);
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
        chk("clr_overflow",  overflow, 1'b0);
        chk("clr_level",     level,    5'd16);

        // Push coincident with a pop while full
        step_to(2 * DIV - 1);
        sample_valid = 1'b1;
        sample_data  = 32'h0000_BEEF;
        step();
        sample_valid = 1'b0;
        chk("coinc_level",    level,    5'd16);
        chk("coinc_overflow", overflow, 1'b0);
        chk("coinc_sync",     dac_sync, 1'b1);
        read_frame(w);
        chk("coinc_frame0", w, 16'h0100);
        for (int k = 1; k <= 16; k++) begin
            step_to(DIV * (2 + k));
            chk("drain_sync", dac_sync, 1'b1);
            read_frame(w);
            exp_w = (k < 16) ? 16'(16'h0100 + k) : 16'hBEEF;
            chk("drain_frame", w, exp_w);
        end
        chk("drained_level",    level,    5'd0);
        chk("drained_underrun", underrun, 1'b0);

        // Empty tick with same-cycle push
        step_to(19 * DIV - 1);
        sample_valid = 1'b1;
        sample_data  = 32'h0000_1234;
        step();
        sample_valid = 1'b0;
        chk("und_sync",  dac_sync, 1'b1);
        chk("und_flag",  underrun, 1'b1);
        chk("und_level", level,    5'd1);
        read_frame(w);
        chk("und_frame", w, 16'h0000);
        step_to(20 * DIV);
        chk("und_next_sync", dac_sync, 1'b1);
        read_frame(w);
        chk("und_next_frame", w, 16'h1234);
        step();
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
        chk("clr_underrun", underrun, 1'b0);

        // Width conversion
        sample_valid = 1'b1;
        sample_data  = 32'h0001_0000;
        step();
        sample_data  = 32'hFFFE_0000;
        step();
        sample_data  = 32'hFFFF_8001;
        step();
        sample_valid = 1'b0;
        step_to(21 * DIV);
        read_frame(w);
`ifdef AUDIO_SAMPLE_SAT_EN
        chk("conv_pos", w, 16'h7FFF);
`else
        chk("conv_pos", w, 16'h0000);
`endif
        step_to(22 * DIV);
        read_frame(w);
`ifdef AUDIO_SAMPLE_SAT_EN
        chk("conv_neg", w, 16'h8000);
`else
        chk("conv_neg", w, 16'h0000);
`endif
        step_to(23 * DIV);
        read_frame(w);
        chk("conv_inrange", w, 16'h8001);

        // Reset in the middle of a frame
        step();
        sample_valid = 1'b1;
        sample_data  = 32'h0000_FFFF;
        step();
        sample_data  = 32'h0000_1111;
        step();
        sample_valid = 1'b0;
        step_to(24 * DIV);
        chk("mid_sync", dac_sync, 1'b1);
        step_to(24 * DIV + 7);
        chk("mid_bit8_sdata", dac_sdata, 1'b1);
        chk("mid_level",      level,     5'd1);
        #1 rst = 1'b0;
        #1;
        chk("async_sdata", dac_sdata,    1'b0);
        chk("async_sync",  dac_sync,     1'b0);
        chk("async_level", level,        5'd0);
        chk("async_ready", sample_ready, 1'b1);
        step();
        rst = 1'b1;
        cyc = 0;
        step_to(DIV - 1);
        chk("rel_pre_sync", dac_sync, 1'b0);
        step();
        chk("rel_tick_sync", dac_sync, 1'b1);
        read_frame(w);
        chk("rel_frame", w, 16'h0000);
        chk("rel_underrun", underrun, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
